// File: rtl/alu_arbiter.sv
// alu_arbiter -- two requesters share one 16-bit ALU through an
// IDLE -> EXEC -> RESP handshake sequence.
//
// Parameters
//   RR_EN       1 = round-robin between requesters, 0 = requester 0 always wins
// Ports
//   clk, rst    single clock, synchronous active-high reset
//   reqN_valid  requester N has an operation pending (N = 0, 1)
//   reqN_ready  requester N operation accepted this cycle
//   reqN_op     3-bit ALU opcode of requester N
//   reqN_a/b    16-bit operands of requester N
//   rsp_valid   response word is valid
//   rsp_ready   consumer accepts the response
//   rsp_id      requester index that owns the response
//   rsp_result  16-bit ALU result
//   rsp_z/v/n   zero, signed-overflow and negative flags of the result
//
// Timing: an operation accepted in cycle c is executed in cycle c+1 and
// presented in cycle c+2, so back-to-back operations issue 3 cycles apart.

// alu_16 -- purely combinational 16-bit ALU.
//   op      000 add, 001 sub, 010 nand, 011 xor, 100 inc, 101 sra, 110 srl, 111 sll
//   a, b    operands; shifts move a by b[3:0] places
//   result  16-bit result
//   z, v, n zero, signed overflow (add/sub/inc only, else 0), negative
module alu_16 (
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        z,
  output logic        v,
  output logic        n
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_SRL  = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  logic signed [15:0] a_signed;

  // Overflow is the two's-complement sign rule: operands that agree in sign
  // (add) or disagree (sub) must not produce a result of the opposite sign.
  always_comb begin
    a_signed = a;
    result   = 16'h0000;
    v        = 1'b0;
    case (op)
      OP_ADD: begin
        result = a + b;
        v      = (a[15] == b[15]) && (result[15] != a[15]);
      end
      OP_SUB: begin
        result = a - b;
        v      = (a[15] != b[15]) && (result[15] != a[15]);
      end
      OP_NAND: result = ~(a & b);
      OP_XOR:  result = a ^ b;
      OP_INC: begin
        result = a + 16'h0001;
        v      = !a[15] && result[15];
      end
      OP_SRA:  result = a_signed >>> b[3:0];
      OP_SRL:  result = a >> b[3:0];
      OP_SLL:  result = a << b[3:0];
      default: result = 16'h0000;
    endcase
    z = (result == 16'h0000);
    n = result[15];
  end

endmodule

module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_z,
  output logic        rsp_v,
  output logic        rsp_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        id_q, id_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic        rsp_z_q, rsp_z_d;
  logic        rsp_v_q, rsp_v_d;
  logic        rsp_n_q, rsp_n_d;

  logic        grant_id;
  logic        accept;
  logic [15:0] alu_result;
  logic        alu_z, alu_v, alu_n;

  // The ALU only ever sees the latched operand registers, so requesters may
  // change their inputs freely once they have been accepted.
  alu_16 u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .z      (alu_z),
    .v      (alu_v),
    .n      (alu_n)
  );

  // Winner selection. With round-robin a tie goes to the requester that was
  // not served last; a lone requester wins regardless of the pointer.
  // Acceptance is blocked while rst is high so a reset cycle never starts
  // an operation.
  always_comb begin
    grant_id = 1'b0;
    if (RR_EN) begin
      if (req0_valid && req1_valid) grant_id = ~last_q;
      else                          grant_id = req1_valid;
    end else begin
      grant_id = !req0_valid;
    end
    accept     = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  // Sequencing: capture the winner's operation on accept, register the ALU
  // output at the end of EXEC, then hold it in RESP until the consumer
  // takes it. rsp_ready outside RESP has no effect.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_z_d      = rsp_z_q;
    rsp_v_d      = rsp_v_q;
    rsp_n_d      = rsp_n_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = grant_id ? req1_op : req0_op;
          a_d     = grant_id ? req1_a  : req0_a;
          b_d     = grant_id ? req1_b  : req0_b;
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_z_d      = alu_z;
        rsp_v_d      = alu_v;
        rsp_n_d      = alu_n;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any operation in flight; the pointer restarts at 1 so
  // requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      op_q         <= 3'b000;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 16'h0000;
      rsp_z_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
      rsp_n_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_z_q      <= rsp_z_d;
      rsp_v_q      <= rsp_v_d;
      rsp_n_q      <= rsp_n_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_v      = rsp_v_q;
  assign rsp_n      = rsp_n_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op / req0_a / req0_b  input  3/16/16  requester 0 ALU opcode and operands.
REQ-007 req1_valid, req1_ready, req1_op, req1_a, req1_b  same as REQ-004..006, for requester 1.
REQ-008 rsp_valid  output  1  response word is valid.
REQ-009 rsp_ready  input  1  consumer accepts the response.
REQ-010 rsp_id  output  1  requester index that owns the response.
REQ-011 rsp_result  output  16  ALU result.
REQ-012 rsp_z / rsp_v / rsp_n  output  1 each  zero, overflow and negative flags of the result.

Function
REQ-013 Block SHALL instantiate exactly one ALU_16 and share it between the two requesters.
REQ-014 Opcodes SHALL pass through unmodified: 000 add, 001 sub, 010 nand, 011 xor, 100 inc, 101 sra, 110 srl, 111 sll.
REQ-015 FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-016 IDLE: if any reqN_valid, assert reqN_ready (combinational) for the winner only; on that edge, latch op/a/b/id into operand registers and go to EXEC; otherwise stay in IDLE.
REQ-017 reqN_ready SHALL be 0 in EXEC and RESP, and 0 for a requester whose valid is 0.
REQ-018 EXEC: ALU_16 SHALL be driven only from the latched operand registers; result and z/v/n SHALL be registered at end of EXEC; next state RESP.
REQ-019 RESP: rsp_valid = 1; rsp_id, rsp_result and flags SHALL hold stable until the cycle rsp_ready = 1, then go to IDLE.
REQ-020 Latency: accept edge -> rsp_valid high 2 cycles later; minimum issue interval 3 cycles per operation.
REQ-021 Arbitration with RR_EN = 1: a 1-bit last-grant pointer; when both valid, grant the requester != last; with a single valid, grant it regardless of pointer; pointer updates only on accept.
REQ-022 Arbitration with RR_EN = 0: requester 0 SHALL win whenever req0_valid = 1.
REQ-023 Requester operands SHALL be sampled only on the accept edge; input changes after acceptance SHALL NOT affect the response.
REQ-024 A requester deasserting valid in IDLE before grant SHALL NOT be granted (no sticky requests).
REQ-025 rsp_ready asserted in IDLE or EXEC SHALL be ignored.

Reset
REQ-026 On rst: state = IDLE, rsp_valid = 0, req0_ready = req1_ready = 0, rsp_id = 0, rsp_result = 16'h0000, rsp_z = rsp_v = rsp_n = 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-027 rst asserted in EXEC or RESP SHALL abort the operation; no response is emitted for it, and the requester is not re-served unless it re-asserts valid.
REQ-028 No request SHALL be accepted in a cycle where rst = 1.

Verification
REQ-029 Single: req0 add a=16'h0003 b=16'h0004, rsp_ready=1 -> rsp_valid 2 cycles after accept, result 16'h0007, id 0, z=v=n=0.
REQ-030 Tie RR: both valid continuously after reset, rsp_ready=1 -> grants 0,1,0,1, each 3 cycles apart; req1 sub 5-5 gives result 0, z=1.
REQ-031 Overflow: req1 add 16'h7FFF + 16'h0001 -> result 16'h8000, v=1, n=1, id 1.
REQ-032 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and outputs stable, both ready=0; release -> IDLE next cycle.
REQ-033 RR_EN=0, both valid continuously -> only requester 0 granted; req1_ready never asserted.
REQ-034 Reset mid-op: rst during EXEC -> next cycle rsp_valid=0, outputs at reset values, state IDLE, pointer=1.
